// File: rtl/csr_unit_pkg.sv
// csr_unit_pkg: M-mode CSR addresses, op encoding, bit positions and RMW helpers.
package csr_unit_pkg;
  typedef logic [11:0] csr_addr_t;
  typedef enum logic [1:0] {CSR_NONE = 2'b00, CSR_RW = 2'b01, CSR_RS = 2'b10, CSR_RC = 2'b11} csr_op_t;
  localparam csr_addr_t CSR_MSTATUS   = 12'h300;
  localparam csr_addr_t CSR_MISA      = 12'h301;
  localparam csr_addr_t CSR_MIE       = 12'h304;
  localparam csr_addr_t CSR_MTVEC     = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
  localparam csr_addr_t CSR_MEPC      = 12'h341;
  localparam csr_addr_t CSR_MCAUSE    = 12'h342;
  localparam csr_addr_t CSR_MTVAL     = 12'h343;
  localparam csr_addr_t CSR_MIP       = 12'h344;
  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
  localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
  localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
  localparam csr_addr_t CSR_MHARTID   = 12'hF14;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;
  localparam logic [31:0] MIE_MASK   = (32'h1 << MIP_MTIP) | (32'h1 << MIP_MEIP);
  localparam logic [31:0] MISA_RV32I = 32'h4000_0100;
  function automatic logic [31:0] csr_wval(csr_op_t op, logic [31:0] old_v, logic [31:0] src);
    return op == CSR_RS ? (old_v | src) : op == CSR_RC ? (old_v & ~src) : src;
  endfunction
  function automatic logic csr_implemented(csr_addr_t a);
    return a inside {CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
                     CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH, CSR_MHARTID};
  endfunction
endpackage

// File: rtl/csr_unit_if.sv
// csr_unit_if: CSR instruction request/response bus between execute stage and CSR unit.
interface csr_unit_if #(parameter int XLEN = 32);
  import csr_unit_pkg::*;
  logic            csr_en;
  csr_op_t         csr_op;
  logic            src_is_zero;
  csr_addr_t       addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            illegal;
  modport master (output csr_en, csr_op, src_is_zero, addr, wdata, input rdata, illegal);
  modport slave  (input csr_en, csr_op, src_is_zero, addr, wdata, output rdata, illegal);
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with increment and independent per-half overwrite.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);
  logic [63:0] cnt_q, cnt_d, sum;
  // the half not being written still takes the carry out of the increment
  always_comb begin
    sum   = cnt_q + {63'd0, inc_i};
    cnt_d = {we_hi_i ? wdata_i : sum[63:32], we_lo_i ? wdata_i : sum[31:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with RMW access, trap/MRET, counters and interrupt gating.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  csr_unit_if.slave       bus,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_valid_i,
  input  logic            instret_inc_i,
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
  output logic            irq_take_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);
  logic            mie_bit_q, mie_bit_d, mpie_q, mpie_d, irq_take_q, irq_take_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] mstatus, mip, old_v, wval;
  logic [63:0]     mcycle, minstret;
  logic            wr_req, ill, we;
  always_comb begin
    mstatus                = '0;
    mstatus[MSTATUS_MIE]   = mie_bit_q;
    mstatus[MSTATUS_MPIE]  = mpie_q;
    mstatus[12:11]         = 2'b11;
    mip                    = '0;
    mip[MIP_MTIP]          = irq_timer_i;
    mip[MIP_MEIP]          = irq_ext_i;
    case (bus.addr)
      CSR_MSTATUS:   old_v = mstatus;
      CSR_MISA:      old_v = MISA_RV32I;
      CSR_MIE:       old_v = mie_q;
      CSR_MTVEC:     old_v = mtvec_q;
      CSR_MSCRATCH:  old_v = mscratch_q;
      CSR_MEPC:      old_v = mepc_q;
      CSR_MCAUSE:    old_v = mcause_q;
      CSR_MTVAL:     old_v = mtval_q;
      CSR_MIP:       old_v = mip;
      CSR_MCYCLE:    old_v = mcycle[31:0];
      CSR_MCYCLEH:   old_v = mcycle[63:32];
      CSR_MINSTRET:  old_v = minstret[31:0];
      CSR_MINSTRETH: old_v = minstret[63:32];
      CSR_MHARTID:   old_v = HART_ID;
      default:       old_v = '0;
    endcase
    wr_req    = bus.csr_en && bus.csr_op != CSR_NONE && !(bus.csr_op != CSR_RW && bus.src_is_zero);
    ill       = bus.csr_en && bus.csr_op != CSR_NONE &&
                (!csr_implemented(bus.addr) || (bus.addr[11:10] == 2'b11 && wr_req));
    we        = wr_req && !ill && !trap_valid_i && !mret_valid_i;
    wval      = csr_wval(bus.csr_op, old_v, bus.wdata);
    bus.rdata   = ill ? '0 : old_v;
    bus.illegal = ill;
  end
  // trap beats MRET beats the CSR write; a losing write is simply dropped
  always_comb begin
    mie_bit_d  = trap_valid_i ? 1'b0 : mret_valid_i ? mpie_q :
                 (we && bus.addr == CSR_MSTATUS) ? wval[MSTATUS_MIE] : mie_bit_q;
    mpie_d     = trap_valid_i ? mie_bit_q : mret_valid_i ? 1'b1 :
                 (we && bus.addr == CSR_MSTATUS) ? wval[MSTATUS_MPIE] : mpie_q;
    mepc_d     = trap_valid_i ? (trap_pc_i & ~32'h3) : (we && bus.addr == CSR_MEPC) ? (wval & ~32'h3) : mepc_q;
    mcause_d   = trap_valid_i ? trap_cause_i : (we && bus.addr == CSR_MCAUSE) ? wval : mcause_q;
    mtval_d    = trap_valid_i ? trap_tval_i : (we && bus.addr == CSR_MTVAL) ? wval : mtval_q;
    mie_d      = (we && bus.addr == CSR_MIE) ? (wval & MIE_MASK) : mie_q;
    mtvec_d    = (we && bus.addr == CSR_MTVEC) ? (wval & ~32'h3) : mtvec_q;
    mscratch_d = (we && bus.addr == CSR_MSCRATCH) ? wval : mscratch_q;
    irq_take_d = mie_bit_q && |(mip & mie_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      irq_take_q <= 1'b0;
    end else begin
      mie_bit_q  <= mie_bit_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      irq_take_q <= irq_take_d;
    end
  end
  if (COUNTERS_EN) begin : g_cnt
    csr_counter64 u_mcycle (
      .clk, .rst_n, .inc_i(1'b1),
      .we_lo_i(we && bus.addr == CSR_MCYCLE), .we_hi_i(we && bus.addr == CSR_MCYCLEH),
      .wdata_i(wval), .cnt_o(mcycle)
    );
    csr_counter64 u_minstret (
      .clk, .rst_n, .inc_i(instret_inc_i),
      .we_lo_i(we && bus.addr == CSR_MINSTRET), .we_hi_i(we && bus.addr == CSR_MINSTRETH),
      .wdata_i(wval), .cnt_o(minstret)
    );
  end else begin : g_nocnt
    assign mcycle   = '0;
    assign minstret = '0;
  end
  assign irq_take_o = irq_take_q;
  assign mtvec_o    = mtvec_q;
  assign mepc_o     = mepc_q;
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed self-checking bench for csr_unit.
module tb_csr_unit;
  import csr_unit_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        trap_valid = 1'b0, mret_valid = 1'b0, instret_inc = 1'b0, irq_timer = 1'b0, irq_ext = 1'b0;
  logic [31:0] trap_cause = '0, trap_pc = '0, trap_tval = '0;
  logic        irq_take;
  logic [31:0] mtvec, mepc, v;
  logic        ill;
  int          n_chk = 0, n_fail = 0;
  csr_unit_if #(.XLEN(32)) bus ();
  csr_unit #(.XLEN(32), .HART_ID(32'h5), .MTVEC_RESET(32'h0000_0100), .COUNTERS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .trap_valid_i(trap_valid), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc), .trap_tval_i(trap_tval),
    .mret_valid_i(mret_valid), .instret_inc_i(instret_inc),
    .irq_timer_i(irq_timer), .irq_ext_i(irq_ext),
    .irq_take_o(irq_take), .mtvec_o(mtvec), .mepc_o(mepc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle_bus();
    bus.csr_en = 1'b0; bus.csr_op = CSR_NONE; bus.addr = '0; bus.wdata = '0; bus.src_is_zero = 1'b0;
  endtask
  task automatic csr_op(input csr_op_t op, input csr_addr_t a, input logic [31:0] d,
                        output logic [31:0] old_v, output logic il);
    bus.csr_en = 1'b1; bus.csr_op = op; bus.addr = a; bus.wdata = d; bus.src_is_zero = 1'b0;
    #1; old_v = bus.rdata; il = bus.illegal;
    @(posedge clk); #1;
    idle_bus();
  endtask
  task automatic rd(input csr_addr_t a, output logic [31:0] val, output logic il);
    bus.csr_en = 1'b1; bus.csr_op = CSR_RS; bus.addr = a; bus.wdata = '0; bus.src_is_zero = 1'b1;
    #1; val = bus.rdata; il = bus.illegal;
    idle_bus();
  endtask
  initial begin
    idle_bus();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_mtvec_o", mtvec, 32'h0000_0100);
    chk("reset_mepc_o", mepc, 32'h0);
    chk("reset_irq_take", {31'd0, irq_take}, 32'h0);
    rd(CSR_MSTATUS, v, ill); chk("reset_mstatus", v, 32'h0000_1800);
    rd(CSR_MISA, v, ill);    chk("misa", v, 32'h4000_0100);
    csr_op(CSR_RW, CSR_MSCRATCH, 32'hDEAD_BEEF, v, ill); chk("mscratch_rw_old", v, 32'h0);
    csr_op(CSR_RS, CSR_MSCRATCH, 32'h0000_00F0, v, ill); chk("mscratch_rs_old", v, 32'hDEAD_BEEF);
    csr_op(CSR_RC, CSR_MSCRATCH, 32'hDE00_0000, v, ill); chk("mscratch_rc_old", v, 32'hDEAD_BEFF);
    rd(CSR_MSCRATCH, v, ill); chk("mscratch_final", v, 32'h00AD_BEFF);
    rd(CSR_MHARTID, v, ill); chk("mhartid_rs_zero_ill", {31'd0, ill}, 32'h0); chk("mhartid_val", v, 32'h5);
    csr_op(CSR_RW, CSR_MHARTID, 32'h7, v, ill);
    chk("mhartid_rw_ill", {31'd0, ill}, 32'h1); chk("mhartid_rw_rdata", v, 32'h0);
    rd(CSR_MHARTID, v, ill); chk("mhartid_unchanged", v, 32'h5);
    rd(12'h7C0, v, ill); chk("unimpl_ill", {31'd0, ill}, 32'h1);
    csr_op(CSR_RW, CSR_MSTATUS, 32'h0000_0008, v, ill);
    rd(CSR_MSTATUS, v, ill); chk("mstatus_mie_set", v, 32'h0000_1808);
    trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_1002; trap_tval = 32'h0000_0ABC;
    csr_op(CSR_RW, CSR_MEPC, 32'h0000_5554, v, ill);
    trap_valid = 1'b0;
    chk("trap_mepc_o", mepc, 32'h0000_1000);
    rd(CSR_MCAUSE, v, ill);  chk("trap_mcause", v, 32'h8000_0007);
    rd(CSR_MTVAL, v, ill);   chk("trap_mtval", v, 32'h0000_0ABC);
    rd(CSR_MSTATUS, v, ill); chk("trap_mstatus", v, 32'h0000_1880);
    mret_valid = 1'b1;
    @(posedge clk); #1 mret_valid = 1'b0;
    rd(CSR_MSTATUS, v, ill); chk("mret_mstatus", v, 32'h0000_1888);
    csr_op(CSR_RW, CSR_MTVEC, 32'h0000_1237, v, ill); chk("mtvec_old", v, 32'h0000_0100);
    chk("mtvec_masked", mtvec, 32'h0000_1234);
    csr_op(CSR_RW, CSR_MCYCLEH, 32'h0, v, ill);
    csr_op(CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF, v, ill);
    rd(CSR_MCYCLE, v, ill); chk("mcycle_written", v, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rd(CSR_MCYCLE, v, ill);    chk("mcycle_wrap", v, 32'h0);
    rd(CSR_MCYCLEH, v, ill);   chk("mcycleh_carry", v, 32'h1);
    rd(CSR_MINSTRET, v, ill);  chk("minstret_idle", v, 32'h0);
    rd(CSR_MINSTRETH, v, ill); chk("minstreth_idle", v, 32'h0);
    instret_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1 instret_inc = 1'b0;
    rd(CSR_MINSTRET, v, ill); chk("minstret_count", v, 32'h3);
    csr_op(CSR_RW, CSR_MIE, 32'hFFFF_FFFF, v, ill);
    rd(CSR_MIE, v, ill); chk("mie_masked", v, 32'h0000_0880);
    irq_timer = 1'b1;
    #1 chk("irq_take_not_yet", {31'd0, irq_take}, 32'h0);
    rd(CSR_MIP, v, ill); chk("mip_mtip", v, 32'h0000_0080);
    @(posedge clk); #1;
    chk("irq_take_rise", {31'd0, irq_take}, 32'h1);
    irq_timer = 1'b0;
    @(posedge clk); #1;
    chk("irq_take_fall", {31'd0, irq_take}, 32'h0);
    irq_timer = 1'b1;
    @(posedge clk); #1;
    chk("irq_take_again", {31'd0, irq_take}, 32'h1);
    csr_op(CSR_RC, CSR_MSTATUS, 32'h0000_0008, v, ill);
    chk("irq_take_lag", {31'd0, irq_take}, 32'h1);
    @(posedge clk); #1;
    chk("irq_take_mie_clr", {31'd0, irq_take}, 32'h0);
    irq_timer = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_mtvec_o", mtvec, 32'h0000_0100);
    chk("async_mepc_o", mepc, 32'h0);
    chk("async_irq_take", {31'd0, irq_take}, 32'h0);
    rd(CSR_MSCRATCH, v, ill); chk("async_mscratch", v, 32'h0);
    rd(CSR_MCYCLEH, v, ill);  chk("async_mcycleh", v, 32'h0);
    rd(CSR_MIE, v, ill);      chk("async_mie", v, 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(CSR_MSTATUS, v, ill); chk("post_reset_mstatus", v, 32'h0000_1800);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
Parametrised machine-mode CSR unit, successor to the flat CSR array. Implements only the architecturally defined M-mode CSRs in discrete registers. Supports CSRRW/CSRRS/CSRRC read-modify-write, trap entry, MRET, 64-bit cycle/instret counters, interrupt pending/enable and illegal-access detection. Sits beside the execute stage; mtvec/mepc feed the PC mux.

Parameters:
XLEN, 32, data width (32 only; counters split low/high)
HART_ID, 0, value returned by mhartid
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
COUNTERS_EN, 1, 1 = mcycle/minstret implemented; 0 = read 0, writes ignored

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
csr_en  in  1  CSR instruction in execute this cycle
csr_op  in  2  csr_op_t: 00 NONE, 01 RW, 10 RS, 11 RC
src_is_zero  in  1  RS/RC source is x0/zero-imm (suppresses write)
addr  in  12  csr_addr_t
wdata  in  XLEN  source operand
rdata  out  XLEN  old CSR value, combinational
illegal  out  1  combinational illegal-access flag
trap_valid  in  1  take exception/interrupt this cycle
trap_cause  in  XLEN  mcause value (bit31 = interrupt)
trap_pc  in  XLEN  faulting PC
trap_tval  in  XLEN  mtval value
mret_valid  in  1  MRET retires this cycle
instret_inc  in  1  one instruction retires
irq_timer  in  1  level, mapped to mip.MTIP (bit 7)
irq_ext  in  1  level, mapped to mip.MEIP (bit 11)
irq_take  out  1  mstatus.MIE & |(mip & mie)
mtvec  out  XLEN  trap vector
mepc  out  XLEN  return address

Behaviour:
- Implemented CSRs: mstatus (MIE b3, MPIE b7, MPP b12:11 reads 2'b11, others 0), misa (RV32I constant), mie (b7, b11 writable), mip (read-only), mtvec, mscratch, mepc, mcause, mtval, mcycle/mcycleh, minstret/minstreth, mhartid.
- Reset (async): all registers 0 except mtvec=MTVEC_RESET; irq_take=0.
- Write value: RW = wdata; RS = old | wdata; RC = old & ~wdata. Write happens in the same posedge as the request. rdata returns the pre-write value.
- Write suppressed when: csr_en=0, op=NONE, (op=RS/RC and src_is_zero), or illegal.
- illegal=1 when csr_en & op!=NONE and either: addr unimplemented, or addr[11:10]==2'b11 (read-only) with a non-suppressed write. Illegal access: no state change, rdata=0.
- Write masks: mtvec[1:0] and mepc[1:0] forced 0; WARL bits not listed read 0.
- Priority per cycle: trap_valid > mret_valid > CSR write. The losing CSR write is dropped.
- Trap: mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0.
- MRET: MIE<=MPIE, MPIE<=1.
- mcycle: +1 every cycle, 64-bit wrap. minstret: +instret_inc, 64-bit wrap. A CSR write to either half in the same cycle replaces that half with the written value (no increment). The other half keeps its incremented value, including carry.
- mip reflects irq inputs combinationally. irq_take is registered one cycle after the condition holds.

Decomposition:
- csr_addr_pkg: add addresses for the new CSRs, csr_op_t, and mstatus bit-position and mip/mie bit-position constants.
- Sub-module csr_counter64: 64-bit counter with inc, per-half write enable and data; instantiated for mcycle and minstret.

Test Plan:
- Reset mid-run (rst_n low asynchronously) -> mtvec=MTVEC_RESET, all other CSRs 0, irq_take=0 without a clock edge.
- RW mscratch 0xDEADBEEF, then RS 0x0000_00F0, then RC 0xDE00_0000 -> rdata returns old values in sequence; final read 0x00ADBEFF.
- RS mhartid with src_is_zero=1 -> illegal=0, rdata=HART_ID. RW mhartid -> illegal=1, no change. Access to 0x7C0 -> illegal=1.
- mstatus.MIE=1, then trap_valid with cause 0x8000_0007, pc 0x0000_1002 -> mepc=0x0000_1000, MIE=0, MPIE=1. MRET -> MIE=1, MPIE=1.
- trap_valid together with a csr_en RW to mepc -> the trap value wins.
- mcycle written to 0xFFFF_FFFF -> next cycle mcycleh increments by 1 and mcycle=0. minstret unchanged with instret_inc=0.
- mie=0x880, MIE=1, irq_timer pulses high -> irq_take=1 one cycle later. Clear MIE -> irq_take drops the next cycle.
